// File: rtl/mdu_controller_pkg.sv
// mdu_controller_pkg
//   Shared definitions for the EX-stage multiply/divide unit: ALU op codes
//   handled by the MDU, the sequencer state type and op-classification helpers.
//   Build option: define MDU_ACC_EN to make MADD/MADDU/MSUB/MSUBU MDU ops.
package mdu_controller_pkg;

    localparam logic [5:0] ALU_SIGNED_MULT   = 6'h18;
    localparam logic [5:0] ALU_UNSIGNED_MULT = 6'h19;
    localparam logic [5:0] ALU_SIGNED_DIV    = 6'h1A;
    localparam logic [5:0] ALU_UNSIGNED_DIV  = 6'h1B;
    localparam logic [5:0] ALU_MADD_MULT     = 6'h1C;
    localparam logic [5:0] ALU_MADDU_MULT    = 6'h1D;
    localparam logic [5:0] ALU_MSUB_MULT     = 6'h1E;
    localparam logic [5:0] ALU_MSUBU_MULT    = 6'h1F;

    typedef enum logic [1:0] {
        MDU_IDLE,
        MDU_MUL_RUN,
        MDU_DIV_RUN,
        MDU_DONE
    } mdu_state_t;

`ifdef MDU_ACC_EN
    function automatic logic is_acc_op(input logic [5:0] code);
        return (code == ALU_MADD_MULT) || (code == ALU_MADDU_MULT) ||
               (code == ALU_MSUB_MULT) || (code == ALU_MSUBU_MULT);
    endfunction

    function automatic logic is_sub_op(input logic [5:0] code);
        return (code == ALU_MSUB_MULT) || (code == ALU_MSUBU_MULT);
    endfunction
`endif

    function automatic logic is_mul_op(input logic [5:0] code);
`ifdef MDU_ACC_EN
        return (code == ALU_SIGNED_MULT) || (code == ALU_UNSIGNED_MULT) || is_acc_op(code);
`else
        return (code == ALU_SIGNED_MULT) || (code == ALU_UNSIGNED_MULT);
`endif
    endfunction

    function automatic logic is_div_op(input logic [5:0] code);
        return (code == ALU_SIGNED_DIV) || (code == ALU_UNSIGNED_DIV);
    endfunction

    function automatic logic is_mdu_op(input logic [5:0] code);
        return is_mul_op(code) || is_div_op(code);
    endfunction

    // Signed variants: operands are treated as two's complement.
    function automatic logic is_signed_op(input logic [5:0] code);
        return (code == ALU_SIGNED_MULT) || (code == ALU_SIGNED_DIV) ||
               (code == ALU_MADD_MULT)   || (code == ALU_MSUB_MULT);
    endfunction

endpackage

// File: rtl/mdu_controller_div.sv
// div_radix2
//   Iterative radix-2 restoring divider. Operands are reduced to magnitudes
//   on start, DIV_ITER iterations run, and signs are fixed on the last step
//   (quotient negated when operand signs differ, remainder follows dividend).
//   A zero divisor skips iteration: quotient = all ones, remainder = a.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          load operands and begin
//   abort          drop the operation in flight (results untouched)
//   signed_div     treat a/b as two's complement
//   a, b           dividend, divisor
//   busy           operation in flight
//   done           high in the cycle whose closing edge writes the results
//   quotient       result, held until the next completed divide
//   remainder      result, held until the next completed divide
module div_radix2 #(
    parameter int unsigned DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        signed_div,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic        zero_q;
    logic        neg_quot_q;
    logic        neg_rem_q;
    logic [5:0]  cnt_q;
    logic [31:0] dvd_q;
    logic [31:0] rem_q;
    logic [31:0] dvs_q;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] dvd_next;
    logic [31:0] rem_next;

    always_comb begin
        a_mag   = (signed_div && a[31]) ? -a : a;
        b_mag   = (signed_div && b[31]) ? -b : b;
        shifted = {rem_q, dvd_q[31]};
        diff    = shifted - {1'b0, dvs_q};
        if (!diff[32]) begin
            rem_next = diff[31:0];
            dvd_next = {dvd_q[30:0], 1'b1};
        end else begin
            rem_next = shifted[31:0];
            dvd_next = {dvd_q[30:0], 1'b0};
        end
        done = busy && (zero_q || (cnt_q == 6'(DIV_ITER - 1)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            zero_q     <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            cnt_q      <= '0;
            dvd_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            quotient   <= '0;
            remainder  <= '0;
        end else if (abort) begin
            busy <= 1'b0;
        end else if (start) begin
            busy       <= 1'b1;
            cnt_q      <= '0;
            zero_q     <= (b == '0);
            neg_quot_q <= signed_div && (a[31] ^ b[31]);
            neg_rem_q  <= signed_div && a[31];
            dvd_q      <= a_mag;
            dvs_q      <= b_mag;
            // Zero divisor parks the raw dividend here as the final remainder.
            rem_q      <= (b == '0) ? a : '0;
        end else if (busy) begin
            if (done) begin
                // Final iteration is folded into the result write.
                busy <= 1'b0;
                if (zero_q) begin
                    quotient  <= '1;
                    remainder <= rem_q;
                end else begin
                    quotient  <= neg_quot_q ? -dvd_next : dvd_next;
                    remainder <= neg_rem_q  ? -rem_next : rem_next;
                end
            end else begin
                dvd_q <= dvd_next;
                rem_q <= rem_next;
                cnt_q <= cnt_q + 6'd1;
            end
        end
    end

endmodule

// File: rtl/mdu_controller.sv
// mdu_controller
//   EX-stage sequencer for the multiply/divide unit. Multiplies run through a
//   MUL_LATENCY-deep pipeline (the last stage is the result register), divides
//   through div_radix2. The pipeline is stalled while busy; the {HI,LO} result
//   is presented with a write enable in DONE.
//   Build option: MDU_ACC_EN adds MADD/MADDU/MSUB/MSUBU with an extra
//   accumulate stage (one more stall cycle).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   alu_controlE    ALU op code in EX
//   src_aE, src_bE  rs / rt operands
//   hi_in, lo_in    current HI/LO (accumulate base)
//   mul_to_gprE     MUL instruction: result goes to rd, HI/LO write suppressed
//   flushE          EX flush, aborts any operation
//   stall_in        downstream stall, holds DONE
//   mdu_stallE      hold IF/ID/EX
//   hilo_weE        HI/LO write enable
//   hilo_outE       {HI,LO} result
//   mul_gpr_outE    low word of the product
module mdu_controller
    import mdu_controller_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 2,
    parameter int unsigned DIV_ITER    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  alu_controlE,
    input  logic [31:0] src_aE,
    input  logic [31:0] src_bE,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    input  logic        mul_to_gprE,
    input  logic        flushE,
    input  logic        stall_in,
    output logic        mdu_stallE,
    output logic        hilo_weE,
    output logic [63:0] hilo_outE,
    output logic [31:0] mul_gpr_outE
);

    mdu_state_t  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        start;
    logic        start_acc;
    logic        op_signed;
    logic        mul_last;
    logic        mul_fin;
    logic        div_fin;
    logic        div_busy;
    logic        div_done;
    logic        mul_gpr_q;
    logic        sel_div_q;
    logic [63:0] ext_a, ext_b;
    logic [63:0] prod_in;
    logic [63:0] mul_tail;
    logic [63:0] mul_result;
    logic [63:0] res_q;
    logic [31:0] div_quot, div_rem;

    always_comb begin
        op_signed = is_signed_op(alu_controlE);
        ext_a     = op_signed ? {{32{src_aE[31]}}, src_aE} : {32'b0, src_aE};
        ext_b     = op_signed ? {{32{src_bE[31]}}, src_bE} : {32'b0, src_bE};
        // Low 64 bits of the extended product are exact for both signednesses.
        prod_in   = ext_a * ext_b;
        start     = (state_q == MDU_IDLE) && !flushE && is_mdu_op(alu_controlE);
    end

    // Free-running shift pipeline: the product issued in the IDLE cycle
    // reaches mul_tail in stall cycle MUL_LATENCY-1.
    if (MUL_LATENCY == 1) begin : g_mul_comb
        assign mul_tail = prod_in;
    end else begin : g_mul_pipe
        logic [63:0] pipe [MUL_LATENCY-1];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned i = 0; i < MUL_LATENCY - 1; i++) pipe[i] <= '0;
            end else begin
                pipe[0] <= prod_in;
                for (int unsigned i = 1; i < MUL_LATENCY - 1; i++) pipe[i] <= pipe[i-1];
            end
        end
        assign mul_tail = pipe[MUL_LATENCY-2];
    end

`ifdef MDU_ACC_EN
    logic        acc_q;
    logic        sub_q;
    logic [63:0] base_q;
    logic [63:0] prod_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= 1'b0;
            sub_q  <= 1'b0;
            base_q <= '0;
            prod_q <= '0;
        end else begin
            prod_q <= mul_tail;
            if (start) begin
                acc_q  <= is_acc_op(alu_controlE);
                sub_q  <= is_sub_op(alu_controlE);
                base_q <= {hi_in, lo_in};
            end
        end
    end

    always_comb begin
        start_acc  = is_acc_op(alu_controlE);
        mul_last   = acc_q ? (cnt_q == 3'(MUL_LATENCY)) : (cnt_q == 3'(MUL_LATENCY - 1));
        mul_result = !acc_q ? mul_tail : (sub_q ? base_q - prod_q : base_q + prod_q);
    end
`else
    logic unused_hilo_in;
    assign unused_hilo_in = ^{hi_in, lo_in};

    always_comb begin
        start_acc  = 1'b0;
        mul_last   = (cnt_q == 3'(MUL_LATENCY - 1));
        mul_result = mul_tail;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MDU_IDLE: begin
                if (start) begin
                    cnt_d = 3'd1;
                    if (is_div_op(alu_controlE))
                        state_d = MDU_DIV_RUN;
                    else if ((MUL_LATENCY == 1) && !start_acc)
                        state_d = MDU_DONE;
                    else
                        state_d = MDU_MUL_RUN;
                end
            end
            MDU_MUL_RUN: begin
                if (mul_last) state_d = MDU_DONE;
                else          cnt_d   = cnt_q + 3'd1;
            end
            MDU_DIV_RUN: begin
                if (div_done) state_d = MDU_DONE;
            end
            MDU_DONE: begin
                if (!stall_in) state_d = MDU_IDLE;
            end
            default: state_d = MDU_IDLE;
        endcase
        if (flushE) state_d = MDU_IDLE;

        mul_fin = (state_d == MDU_DONE) &&
                  ((state_q == MDU_IDLE) || (state_q == MDU_MUL_RUN));
        div_fin = (state_d == MDU_DONE) && (state_q == MDU_DIV_RUN);

        mdu_stallE = !flushE && (start || (state_q == MDU_MUL_RUN) ||
                                 ((state_q == MDU_DIV_RUN) && div_busy));
        hilo_weE   = (state_q == MDU_DONE) && !mul_gpr_q && !flushE;
    end

    // Result sources only change on entry to DONE, so an aborted op
    // leaves the previously presented result untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MDU_IDLE;
            cnt_q     <= '0;
            mul_gpr_q <= 1'b0;
            sel_div_q <= 1'b0;
            res_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (start) mul_gpr_q <= mul_to_gprE;
            if (mul_fin) begin
                res_q     <= (state_q == MDU_IDLE) ? mul_tail : mul_result;
                sel_div_q <= 1'b0;
            end
            if (div_fin) sel_div_q <= 1'b1;
        end
    end

    div_radix2 #(
        .DIV_ITER (DIV_ITER)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start      (start && is_div_op(alu_controlE)),
        .abort      (flushE),
        .signed_div (op_signed),
        .a          (src_aE),
        .b          (src_bE),
        .busy       (div_busy),
        .done       (div_done),
        .quotient   (div_quot),
        .remainder  (div_rem)
    );

    assign hilo_outE    = sel_div_q ? {div_rem, div_quot} : res_q;
    assign mul_gpr_outE = res_q[31:0];

endmodule

// File: tb/tb_mdu_controller.sv
// tb_mdu_controller
//   Directed bench for mdu_controller (MUL_LATENCY=2, DIV_ITER=32).
//   Honours MDU_ACC_EN for the accumulate cases.
module tb_mdu_controller;
    import mdu_controller_pkg::*;

    localparam logic [5:0] NOP = 6'h00;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  alu_controlE;
    logic [31:0] src_aE, src_bE, hi_in, lo_in;
    logic        mul_to_gprE, flushE, stall_in;
    logic        mdu_stallE, hilo_weE;
    logic [63:0] hilo_outE;
    logic [31:0] mul_gpr_outE;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int          st;
    int          we_seen;

    mdu_controller #(
        .MUL_LATENCY (2),
        .DIV_ITER    (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_controlE (alu_controlE),
        .src_aE       (src_aE),
        .src_bE       (src_bE),
        .hi_in        (hi_in),
        .lo_in        (lo_in),
        .mul_to_gprE  (mul_to_gprE),
        .flushE       (flushE),
        .stall_in     (stall_in),
        .mdu_stallE   (mdu_stallE),
        .hilo_weE     (hilo_weE),
        .hilo_outE    (hilo_outE),
        .mul_gpr_outE (mul_gpr_outE)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Presents an op and counts stall cycles; returns at the negedge of the
    // first non-stalled cycle (DONE for an MDU op).
    task automatic issue(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                         input logic gpr, input logic [31:0] hi, input logic [31:0] lo,
                         output int stalls);
        alu_controlE = code;
        src_aE       = a;
        src_bE       = b;
        mul_to_gprE  = gpr;
        hi_in        = hi;
        lo_in        = lo;
        stalls       = 0;
        sample();
        while (mdu_stallE === 1'b1 && stalls < 100) begin
            stalls++;
            next_cycle();
            sample();
        end
    endtask

    task automatic finish_op();
        next_cycle();
        alu_controlE = NOP;
        mul_to_gprE  = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        alu_controlE = NOP;
        src_aE       = '0;
        src_bE       = '0;
        hi_in        = '0;
        lo_in        = '0;
        mul_to_gprE  = 1'b0;
        flushE       = 1'b0;
        stall_in     = 1'b0;

        // Reset state
        next_cycle();
        next_cycle();
        sample();
        check("reset_stall", 64'(mdu_stallE), 64'd0);
        check("reset_we",    64'(hilo_weE),   64'd0);
        check("reset_hilo",  hilo_outE,       64'd0);
        check("reset_gpr",   64'(mul_gpr_outE), 64'd0);
        next_cycle();
        rst = 1'b0;

        // MULT -1 * 2
        issue(ALU_SIGNED_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, '0, '0, st);
        check("mult_stalls", 64'(st), 64'd2);
        check("mult_we",     64'(hilo_weE), 64'd1);
        check("mult_hilo",   hilo_outE, 64'hFFFF_FFFF_FFFF_FFFE);
        finish_op();

        // DIVU 100/7
        issue(ALU_UNSIGNED_DIV, 32'd100, 32'd7, 1'b0, '0, '0, st);
        check("divu_stalls", 64'(st), 64'd33);
        check("divu_we",     64'(hilo_weE), 64'd1);
        check("divu_hilo",   hilo_outE, {32'd2, 32'd14});
        finish_op();

        // DIV -7/2
        issue(ALU_SIGNED_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, '0, '0, st);
        check("div_stalls", 64'(st), 64'd33);
        check("div_we",     64'(hilo_weE), 64'd1);
        check("div_hilo",   hilo_outE, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        finish_op();

        // DIV 5/0
        issue(ALU_SIGNED_DIV, 32'd5, 32'd0, 1'b0, '0, '0, st);
        check("div0_stalls", 64'(st), 64'd2);
        check("div0_we",     64'(hilo_weE), 64'd1);
        check("div0_hilo",   hilo_outE, {32'd5, 32'hFFFF_FFFF});
        finish_op();

        // DIVU flushed in its 11th stall cycle, then MULTU 3*4
        alu_controlE = ALU_UNSIGNED_DIV;
        src_aE       = 32'd100;
        src_bE       = 32'd7;
        for (int i = 0; i < 10; i++) begin
            sample();
            check("flush_pre_stall", 64'(mdu_stallE), 64'd1);
            next_cycle();
        end
        flushE = 1'b1;
        sample();
        check("flush_stall", 64'(mdu_stallE), 64'd0);
        check("flush_we",    64'(hilo_weE),   64'd0);
        check("flush_hold",  hilo_outE, {32'd5, 32'hFFFF_FFFF});
        next_cycle();
        flushE = 1'b0;
        issue(ALU_UNSIGNED_MULT, 32'd3, 32'd4, 1'b0, '0, '0, st);
        check("multu_stalls", 64'(st), 64'd2);
        check("multu_we",     64'(hilo_weE), 64'd1);
        check("multu_hilo",   hilo_outE, 64'd12);
        finish_op();

        // MUL to GPR: HI/LO write suppressed
        issue(ALU_SIGNED_MULT, 32'd3, 32'd4, 1'b1, '0, '0, st);
        check("mul_stalls", 64'(st), 64'd2);
        check("mul_we",     64'(hilo_weE), 64'd0);
        check("mul_gpr",    64'(mul_gpr_outE), 64'd12);
        finish_op();

`ifdef MDU_ACC_EN
        issue(ALU_MADD_MULT, 32'd3, 32'd4, 1'b0, 32'd0, 32'd1, st);
        check("madd_stalls", 64'(st), 64'd3);
        check("madd_we",     64'(hilo_weE), 64'd1);
        check("madd_hilo",   hilo_outE, 64'd13);
        finish_op();
        issue(ALU_MSUBU_MULT, 32'd3, 32'd4, 1'b0, 32'd0, 32'd20, st);
        check("msubu_stalls", 64'(st), 64'd3);
        check("msubu_hilo",   hilo_outE, 64'd8);
        finish_op();
`else
        alu_controlE = ALU_MADD_MULT;
        src_aE       = 32'd3;
        src_bE       = 32'd4;
        lo_in        = 32'd1;
        sample();
        check("madd_off_stall", 64'(mdu_stallE), 64'd0);
        check("madd_off_we",    64'(hilo_weE),   64'd0);
        next_cycle();
        sample();
        check("madd_off_stall2", 64'(mdu_stallE), 64'd0);
        check("madd_off_hold",   hilo_outE, 64'd12);
        next_cycle();
        alu_controlE = NOP;
        lo_in        = '0;
`endif

        // DONE held by stall_in
        stall_in = 1'b1;
        issue(ALU_UNSIGNED_MULT, 32'd5, 32'd6, 1'b0, '0, '0, st);
        check("hold_stalls", 64'(st), 64'd2);
        check("hold_we0",    64'(hilo_weE), 64'd1);
        check("hold_hilo0",  hilo_outE, 64'd30);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            sample();
            check("hold_we",    64'(hilo_weE),   64'd1);
            check("hold_stall", 64'(mdu_stallE), 64'd0);
            check("hold_hilo",  hilo_outE, 64'd30);
        end
        next_cycle();
        stall_in = 1'b0;
        sample();
        check("release_we", 64'(hilo_weE), 64'd1);
        next_cycle();
        alu_controlE = NOP;
        sample();
        check("idle_we",    64'(hilo_weE),   64'd0);
        check("idle_stall", 64'(mdu_stallE), 64'd0);
        check("idle_hilo",  hilo_outE, 64'd30);
        next_cycle();
        sample();
        check("idle_we2", 64'(hilo_weE), 64'd0);
        next_cycle();

        // Reset in the middle of a divide
        alu_controlE = ALU_UNSIGNED_DIV;
        src_aE       = 32'd100;
        src_bE       = 32'd7;
        for (int i = 0; i < 5; i++) begin
            sample();
            next_cycle();
        end
        rst          = 1'b1;
        alu_controlE = NOP;
        next_cycle();
        rst = 1'b0;
        sample();
        check("rstdiv_stall", 64'(mdu_stallE),   64'd0);
        check("rstdiv_we",    64'(hilo_weE),     64'd0);
        check("rstdiv_hilo",  hilo_outE,         64'd0);
        check("rstdiv_gpr",   64'(mul_gpr_outE), 64'd0);
        we_seen = 0;
        for (int i = 0; i < 40; i++) begin
            next_cycle();
            sample();
            if (hilo_weE !== 1'b0 || mdu_stallE !== 1'b0) we_seen++;
        end
        check("rstdiv_discarded", 64'(we_seen), 64'd0);
        check("rstdiv_hilo_end",  hilo_outE, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_controller.md
Name: mdu_controller

Overview:
- EX-stage sequencer for the multiply/divide unit of the pipelined MIPS core.
- Takes the decoded alu_control code plus operands and runs the multi-cycle operation:
  - pipelined multiplier for MULT/MULTU/MUL and MADD/MSUB variants;
  - iterative radix-2 divider for DIV/DIVU.
- Stalls the pipeline while busy, then presents the 64-bit HI/LO result with a write enable.

Parameters:
- MUL_LATENCY, 2: registered multiplier stages. Equals the stall cycles for a multiply. Legal range 1-4.
- DIV_ITER, 32: divider iterations. Fixed by the 32-bit operand width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- alu_controlE  in  6  ALU code from alu_decoder, registered into EX
- src_aE  in  32  rs value (dividend / multiplicand)
- src_bE  in  32  rt value (divisor / multiplier)
- hi_in  in  32  current HI; used by the accumulate ops
- lo_in  in  32  current LO
- mul_to_gprE  in  1  instruction is MUL, which writes rd; HI/LO write suppressed
- flushE  in  1  EX flush (exception/eret); aborts any operation
- stall_in  in  1  downstream stall; the EX instruction is not advancing
- mdu_stallE  out  1  hold IF/ID/EX
- hilo_weE  out  1  HI/LO write enable
- hilo_outE  out  64  {HI,LO} result
- mul_gpr_outE  out  32  low 32 bits of the product, for MUL

Behaviour:
- States: IDLE, MUL_RUN, DIV_RUN, DONE.
- Reset (rst=1 at clk edge):
  - state=IDLE, counter=0;
  - all outputs 0, hilo_outE=0;
  - any in-flight divide is discarded.
- MDU op set: ALU_SIGNED_MULT, ALU_UNSIGNED_MULT, ALU_SIGNED_DIV, ALU_UNSIGNED_DIV, plus ALU_MADD_MULT/MADDU/MSUB/MSUBU (see optional feature). Any other code: no stall, hilo_weE=0.
- IDLE:
  - An MDU op with flushE=0 asserts mdu_stallE combinationally in the same cycle.
  - Operands, hi_in/lo_in, the op code and mul_to_gprE are latched at that edge.
  - Multiply ops go to MUL_RUN; divide ops go to DIV_RUN.
- MUL_RUN:
  - Counter runs to MUL_LATENCY-1, then goes to DONE.
  - Total stall cycles = MUL_LATENCY, including the IDLE cycle.
  - Signed ops use two's-complement 32x32->64; unsigned ops use zero extension.
- DIV_RUN:
  - Divider sub-module is started on the IDLE edge and takes DIV_ITER cycles, then DONE. Total stall = 33 cycles.
  - Signed divide: divide magnitudes, then fix signs. Quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - Divisor 0: skip iterations and go to DONE next cycle (stall = 2) with HI=src_a, LO=0xFFFFFFFF.
- DONE:
  - mdu_stallE=0 and hilo_weE=1, unless mul_to_gprE, in which case hilo_weE=0.
  - hilo_outE = {HI=remainder or product[63:32], LO=quotient or product[31:0]}.
  - stall_in=1: remain in DONE with outputs stable. Rewriting the same latched value is idempotent.
  - stall_in=0: go to IDLE. No new op is accepted in the DONE cycle.
- flushE=1 in any state:
  - next state IDLE, divider aborted, hilo_weE=0 that cycle;
  - mdu_stallE=0 in the same cycle, combinationally gated.
- Outputs hold their last value in IDLE, except hilo_weE=0 and mdu_stallE as defined above.
- Overlap rules:
  - An MDU op arriving while RUN is active cannot occur, since the pipeline is stalled.
  - A back-to-back MDU op after DONE starts from IDLE on the next cycle.

Optional Feature:
- Macro MDU_ACC_EN.
- Defined: MADD/MADDU/MSUB/MSUBU are MDU ops.
  - Result = {hi_in,lo_in} ± product, using hi_in/lo_in latched at start.
  - Accumulation is done in a final adder stage, adding 1 cycle: stall = MUL_LATENCY+1.
- Undefined: those codes are treated as non-MDU ops (no stall, hilo_weE=0) and the accumulator adder is removed.

Decomposition:
- State encodings (MDU_IDLE, MDU_MUL_RUN, MDU_DIV_RUN, MDU_DONE) go in aludefines.vh; the ALU_* op codes are already there.
- Sub-module div_radix2:
  - ports clk, rst, start, abort, signed_div, a, b, busy, done, quotient, remainder;
  - unsigned restoring core plus sign fix.
- The multiplier stays inline.

Test Plan:
- MULT src_a=0xFFFFFFFF, src_b=2 (MUL_LATENCY=2) -> 2 stall cycles, then hilo_weE=1, hilo_outE=0xFFFFFFFF_FFFFFFFE.
- DIVU 100/7 -> 33 stall cycles, then HI=2, LO=14. DIV -7/2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFD.
- DIV 5/0 -> stall 2 cycles, HI=5, LO=0xFFFFFFFF.
- DIVU started, flushE=1 at cycle 10 -> stall drops that cycle, no hilo_weE. MULTU 3*4 issued next cycle -> {0,12}.
- MADD (MDU_ACC_EN), hi_in=0, lo_in=1, 3*4 -> 3 stall cycles, LO=13. MUL with mul_to_gprE=1 -> mul_gpr_outE=12, hilo_weE=0.
- DONE with stall_in=1 for 3 cycles -> outputs stable, state held. stall_in=0 -> IDLE, no re-issue. rst mid-DIV -> IDLE, all outputs 0.
